// File: rtl/dev_bus_pkg.sv
// Shared types and constants for the device-bus arbiter: FSM states, CLINT map, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dev_bus_pkg;

    localparam int XLEN = 32;

    // Default idle cycles before an abandoned lock is force-released.
    localparam int LOCK_TIMEOUT_DEF = 8;

    // CLINT register offsets on the device bus.
    localparam logic [XLEN-1:0] CLINT_MSIP     = 32'h0000_0000;
    localparam logic [XLEN-1:0] CLINT_MTIMECMP = 32'h0000_4000;
    localparam logic [XLEN-1:0] CLINT_MTIME    = 32'h0000_BFF8;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dev_bus_arbiter_rr_pick.sv
// Round-robin priority picker: first set request after the pointer wins.
// Latency: purely combinational.
// Backpressure: none; losers simply see no winner flag for themselves.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    // Scan offsets 1..N from the pointer so the last winner has lowest priority.
    always_comb begin
        int k;
        k        = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        for (int off = 1; off <= N; off++) begin
            k = (int'(i_ptr) + off) % N;
            if (!o_vld && i_req[k]) begin
                o_vld       = 1'b1;
                o_idx       = IW'(k);
                o_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Round-robin arbiter sharing the single-ported device bus; optional locked sequences (DEV_ARB_LOCK_EN).
// Latency: grant same cycle as request, registered response exactly one cycle after grant.
// Backpressure: requesters hold req/we/addr/data until they see m_gnt_o; one access per cycle.
module dev_bus_arbiter
    import dev_bus_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      m_req_i,
    input  logic [NUM_REQ-1:0]      m_we_i,
    input  logic [NUM_REQ-1:0]      m_lock_i,
    input  logic [NUM_REQ*XLEN-1:0] m_addr_i,
    input  logic [NUM_REQ*XLEN-1:0] m_wdata_i,
    output logic [NUM_REQ-1:0]      m_gnt_o,
    output logic [NUM_REQ-1:0]      m_rvalid_o,
    output logic [XLEN-1:0]         m_rdata_o,
    output logic                    dev_req_o,
    output logic                    dev_we_o,
    output logic [XLEN-1:0]         dev_addr_o,
    output logic [XLEN-1:0]         dev_data_o,
    input  logic [XLEN-1:0]         dev_data_i,
    output logic                    lock_active_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      r_rr_ptr;
    logic [NUM_REQ-1:0] r_rvalid;
    logic [XLEN-1:0]    r_rdata;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_win_oh;
    logic [IW-1:0]      w_win_idx;
    logic               w_win_vld;
    logic               w_gnt;

`ifdef DEV_ARB_LOCK_EN
    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      w_owner_nxt;
    logic [7:0]         r_idle_cnt;
    logic [7:0]         w_idle_nxt;
    logic [NUM_REQ-1:0] w_owner_oh;

    // While locked only the owner may compete; everybody else is masked out.
    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
        w_elig              = (r_state == LOCKED) ? (m_req_i & w_owner_oh) : m_req_i;
    end

    assign lock_active_o = (r_state == LOCKED);
`else
    logic w_unused_lock;

    // Lock input and timeout have no function in the plain round-robin build.
    assign w_unused_lock = (^m_lock_i) ^ (LOCK_TIMEOUT > 0);
    assign w_elig        = m_req_i;
    assign lock_active_o = 1'b0;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req    (w_elig),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_vld    (w_win_vld)
    );

    // No grant may leave the block while reset is asserted.
    assign w_gnt = w_win_vld & rst_ni;

    // Steer the winner onto the device bus; idle bus drives all zeros.
    always_comb begin
        m_gnt_o    = '0;
        dev_req_o  = 1'b0;
        dev_we_o   = 1'b0;
        dev_addr_o = '0;
        dev_data_o = '0;
        if (w_gnt) begin
            m_gnt_o    = w_win_oh;
            dev_req_o  = 1'b1;
            dev_we_o   = m_we_i[w_win_idx];
            dev_addr_o = m_addr_i[int'(w_win_idx)*XLEN +: XLEN];
            dev_data_o = m_wdata_i[int'(w_win_idx)*XLEN +: XLEN];
        end
    end

    // Rotate priority and capture the response; writes return zero data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr <= IW'(NUM_REQ - 1);
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else if (w_gnt) begin
            r_rr_ptr <= w_win_idx;
            r_rvalid <= w_win_oh;
            r_rdata  <= dev_we_o ? '0 : dev_data_i;
        end else begin
            r_rvalid <= '0;
        end
    end

    assign m_rvalid_o = r_rvalid;
    assign m_rdata_o  = r_rdata;

`ifdef DEV_ARB_LOCK_EN
    // Lock FSM state, owner and idle counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ARB;
            r_owner    <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_idle_cnt <= w_idle_nxt;
        end
    end

    // Enter on a locked grant, leave on an unlocked owner access or idle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_idle_nxt  = r_idle_cnt;
        case (r_state)
            ARB: begin
                if (w_gnt && m_lock_i[w_win_idx]) begin
                    w_state_nxt = LOCKED;
                    w_owner_nxt = w_win_idx;
                    w_idle_nxt  = '0;
                end
            end
            LOCKED: begin
                if (w_gnt) begin
                    w_idle_nxt = '0;
                    if (!m_lock_i[w_win_idx]) begin
                        w_state_nxt = ARB;
                    end
                end else if (r_idle_cnt == 8'(LOCK_TIMEOUT - 1)) begin
                    // Abandoned lock: release without issuing an access.
                    w_state_nxt = ARB;
                    w_idle_nxt  = '0;
                end else begin
                    w_idle_nxt = r_idle_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end
`endif

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Directed bench for dev_bus_arbiter: round-robin, writes, locking, timeout, reset mid-lock.
// Latency: checks combinational outputs #1 after the falling edge, registered ones after the rising edge.
// Backpressure: requests are held while the bench expects them to be pending.
module tb_dev_bus_arbiter;
    import dev_bus_pkg::*;

`ifdef DEV_ARB_LOCK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    localparam logic [31:0] D0  = 32'h0000_0111;
    localparam logic [31:0] DX  = 32'h5A5A_0000;
    localparam logic [31:0] RT  = CLINT_MTIME ^ DX;           // read data of 0xBFF8
    localparam logic [31:0] RTH = (CLINT_MTIME + 32'h4) ^ DX; // read data of 0xBFFC
    localparam logic [31:0] RS  = CLINT_MSIP ^ DX;            // read data of 0x0000

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  m_req_i, m_we_i, m_lock_i;
    logic [63:0] m_addr_i, m_wdata_i;
    logic [1:0]  m_gnt_o, m_rvalid_o;
    logic [31:0] m_rdata_o;
    logic        dev_req_o, dev_we_o;
    logic [31:0] dev_addr_o, dev_data_o, dev_data_i;
    logic        lock_active_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    // Device model: read data is a fixed function of the address.
    assign dev_data_i = dev_addr_o ^ DX;

    dev_bus_arbiter #(
        .NUM_REQ      (2),
        .LOCK_TIMEOUT (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .m_req_i       (m_req_i),
        .m_we_i        (m_we_i),
        .m_lock_i      (m_lock_i),
        .m_addr_i      (m_addr_i),
        .m_wdata_i     (m_wdata_i),
        .m_gnt_o       (m_gnt_o),
        .m_rvalid_o    (m_rvalid_o),
        .m_rdata_o     (m_rdata_o),
        .dev_req_o     (dev_req_o),
        .dev_we_o      (dev_we_o),
        .dev_addr_o    (dev_addr_o),
        .dev_data_o    (dev_data_o),
        .dev_data_i    (dev_data_i),
        .lock_active_o (lock_active_o)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req, we, lock;
        logic [31:0] a0, a1, d1;
        logic [1:0]  e_gnt;
        logic        e_we;
        logic [31:0] e_addr, e_data;
        logic [1:0]  e_rv;
        logic [31:0] e_rd;
        logic        e_lk;
    } vec_t;

    function automatic vec_t mk(logic rst, logic [1:0] req, logic [1:0] we, logic [1:0] lock,
                                logic [31:0] a0, logic [31:0] a1, logic [31:0] d1,
                                logic [1:0] gnt, logic dwe, logic [31:0] addr, logic [31:0] data,
                                logic [1:0] rv, logic [31:0] rd, logic lk);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.lock = lock;
        v.a0 = a0; v.a1 = a1; v.d1 = d1;
        v.e_gnt = gnt; v.e_we = dwe; v.e_addr = addr; v.e_data = data;
        v.e_rv = rv; v.e_rd = rd; v.e_lk = lk;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check everything.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk_i);
        rst_ni    = v.rst;
        m_req_i   = v.req;
        m_we_i    = v.we;
        m_lock_i  = v.lock;
        m_addr_i  = {v.a1, v.a0};
        m_wdata_i = {v.d1, D0};
        #1;
        chk("gnt",      idx, 32'(m_gnt_o),       32'(v.e_gnt));
        chk("dev_req",  idx, 32'(dev_req_o),     32'(|v.e_gnt));
        chk("dev_we",   idx, 32'(dev_we_o),      32'(v.e_we));
        chk("dev_addr", idx, dev_addr_o,         v.e_addr);
        chk("dev_data", idx, dev_data_o,         v.e_data);
        chk("rvalid",   idx, 32'(m_rvalid_o),    32'(v.e_rv));
        chk("rdata",    idx, m_rdata_o,          v.e_rd);
        chk("lock_act", idx, 32'(lock_active_o), 32'(v.e_lk));
    endtask

    vec_t tbl[$];
    vec_t seq[$];

    initial begin
        rst_ni    = 1'b0;
        m_req_i   = '0;
        m_we_i    = '0;
        m_lock_i  = '0;
        m_addr_i  = '0;
        m_wdata_i = '0;
        repeat (2) @(posedge clk_i);

        // Reset held with requests pending, then released with nothing pending.
        tbl.push_back(mk(0, 2'b11, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b00, 0, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b00, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b00, 0, 0, 0, 2'b00, 0, 0));
        // Both requesters held: requester 0 first, then alternation.
        tbl.push_back(mk(1, 2'b11, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b01, 0, CLINT_MTIME, D0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b11, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b10, 0, CLINT_MSIP, 32'h222, 2'b01, RT, 0));
        tbl.push_back(mk(1, 2'b11, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b01, 0, CLINT_MTIME, D0, 2'b10, RS, 0));
        tbl.push_back(mk(1, 2'b00, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b00, 0, 0, 0, 2'b01, RT, 0));
        // Requester 1 writes mtimecmp; response carries zero data.
        tbl.push_back(mk(1, 2'b10, 2'b10, 0, CLINT_MSIP, CLINT_MTIMECMP, 32'h10, 2'b10, 1, CLINT_MTIMECMP, 32'h10, 2'b00, RT, 0));
        tbl.push_back(mk(1, 2'b00, 0, 0, CLINT_MSIP, CLINT_MSIP, 32'h222, 2'b00, 0, 0, 0, 2'b10, 0, 0));
        // Single request, then pointer at 0 lets requester 1 win a tie.
        tbl.push_back(mk(1, 2'b01, 0, 0, CLINT_MSIP, CLINT_MSIP, 32'h222, 2'b01, 0, CLINT_MSIP, D0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b11, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b10, 0, CLINT_MSIP, 32'h222, 2'b01, RS, 0));
        tbl.push_back(mk(1, 2'b00, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b00, 0, 0, 0, 2'b10, RS, 0));
        foreach (tbl[i]) apply(tbl[i], i);

        // Locked mtime pair read by requester 0 while requester 1 waits.
        seq.push_back(mk(1, 2'b11, 0, 2'b01, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b01, 0, CLINT_MTIME, D0, 2'b00, RS, 0));
        seq.push_back(mk(1, 2'b11, 0, 2'b00, CLINT_MTIME + 32'h4, CLINT_MSIP, 32'h222,
                         EN ? 2'b01 : 2'b10, 0, EN ? CLINT_MTIME + 32'h4 : CLINT_MSIP, EN ? D0 : 32'h222,
                         2'b01, RT, EN));
        seq.push_back(mk(1, 2'b10, 0, 0, CLINT_MSIP, CLINT_MSIP, 32'h222, 2'b10, 0, CLINT_MSIP, 32'h222,
                         EN ? 2'b01 : 2'b10, EN ? RTH : RS, 0));
        // Abandoned lock: four idle cycles, release, then requester 1 served.
        seq.push_back(mk(1, 2'b11, 0, 2'b01, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b01, 0, CLINT_MTIME, D0, 2'b10, RS, 0));
        seq.push_back(mk(1, 2'b10, 0, 0, CLINT_MSIP, CLINT_MSIP, 32'h222, EN ? 2'b00 : 2'b10, 0, 0,
                         EN ? 32'h0 : 32'h222, 2'b01, RT, EN));
        for (int c = 0; c < 3; c++)
            seq.push_back(mk(1, 2'b10, 0, 0, CLINT_MSIP, CLINT_MSIP, 32'h222, EN ? 2'b00 : 2'b10, 0, 0,
                             EN ? 32'h0 : 32'h222, EN ? 2'b00 : 2'b10, EN ? RT : RS, EN));
        seq.push_back(mk(1, 2'b10, 0, 0, CLINT_MSIP, CLINT_MSIP, 32'h222, 2'b10, 0, CLINT_MSIP, 32'h222,
                         EN ? 2'b00 : 2'b10, EN ? RT : RS, 0));
        // Reset for one edge while locked: state cleared, requester 0 wins next.
        seq.push_back(mk(1, 2'b11, 0, 2'b01, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b01, 0, CLINT_MTIME, D0, 2'b10, RS, 0));
        seq.push_back(mk(0, 2'b11, 0, 2'b01, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b00, 0, 0, 0, 2'b01, RT, EN));
        seq.push_back(mk(1, 2'b11, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b01, 0, CLINT_MTIME, D0, 2'b00, 0, 0));
        seq.push_back(mk(1, 2'b00, 0, 0, CLINT_MTIME, CLINT_MSIP, 32'h222, 2'b00, 0, 0, 0, 2'b01, RT, 0));
        foreach (seq[i]) apply(seq[i], 100 + i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
